// File: rtl/neo_pbus_pkg.sv
// Shared definitions for the NeoGeo P-bus transmitter: FSM encoding, slot types,
// field widths and the CA/SA to PBUS word packing.
package neo_pbus_pkg;

   localparam int PBUS_W  = 20;
   localparam int CTILE_W = 16;
   localparam int STILE_W = 12;
   localparam int CLINE_W = 4;
   localparam int SLINE_W = 3;
   localparam int CA_W    = CTILE_W + CLINE_W;
   localparam int SA_W    = STILE_W + 1 + SLINE_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   typedef enum logic {
      SLOT_C = 1'b0,
      SLOT_S = 1'b1
   } slot_t;

   // C slot puts the tile on the low 16 lines and the tile line on the top nibble.
   function automatic logic [PBUS_W-1:0] packC(input logic [CA_W-1:0] ca);
      return {ca[3:0], ca[19:4]};
   endfunction

   // S slot uses only the low 16 lines; the top nibble is driven low.
   function automatic logic [PBUS_W-1:0] packS(input logic [SA_W-1:0] sa);
      return {4'h0, sa[3:0], sa[15:4]};
   endfunction

endpackage

// File: rtl/neo_pbus_reqbuf.sv
// One-entry valid/ready request buffer. The entry may be refilled in the same
// cycle it is freed, which lets back-to-back slots run without an idle gap.
module neo_pbus_reqbuf
   import neo_pbus_pkg::*;
#(
   parameter int W = CA_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   input  logic         free_i,
   output logic         ready_o,
   output logic         accept_o,
   output logic         full_o,
   output logic [W-1:0] data_o
);

   logic         alive_q;
   logic         full_q;
   logic [W-1:0] data_q;

   // alive_q keeps READY low while in reset and raises it on the first edge after release.
   assign ready_o  = alive_q & (~full_q | free_i);
   assign accept_o = valid_i & ready_o;
   assign full_o   = full_q;
   assign data_o   = data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive_q <= 1'b0;
         full_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         alive_q <= 1'b1;
         if (accept_o) begin
            full_q <= 1'b1;
            data_q <= data_i;
         end else if (free_i) begin
            full_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/neo_pbus_tx.sv
// NeoGeo P-bus transmit end: arbitrates sprite (C) and fix (S) fetches onto PBUS
// with setup/strobe/hold framing. Define NEO_PBUS_VFLIP_EN to honour C_VFLIP.
module neo_pbus_tx
   import neo_pbus_pkg::*;
#(
   parameter int SETUP_CYC = 1,
   parameter int HOLD_CYC  = 1,
   parameter int FAIR_MAX  = 2
) (
   input  logic                CLK,
   input  logic                nRESET,
   input  logic                C_VALID,
   output logic                C_READY,
   input  logic [CTILE_W-1:0]  C_TILE,
   input  logic [CLINE_W-1:0]  C_LINE,
   input  logic                C_VFLIP,
   input  logic                S_VALID,
   output logic                S_READY,
   input  logic [STILE_W-1:0]  S_TILE,
   input  logic                S_HALF,
   input  logic [SLINE_W-1:0]  S_LINE,
   output logic [PBUS_W-1:0]   PBUS,
   output logic                PBUS_OE,
   output logic                PCK1B_EN,
   output logic                PCK2B_EN,
   output logic                BUSY
);

   state_t              state_q, state_d;
   slot_t               slot_q, slot_d;
   logic [2:0]          tmr_q, tmr_d;
   logic [3:0]          fair_q, fair_d;
   logic [PBUS_W-1:0]   pbus_q, pbus_d;
   logic                oe_q, oe_d;

   logic [CLINE_W-1:0]  cLineEff;
   logic [CA_W-1:0]     cIn, cData, cSel;
   logic [SA_W-1:0]     sIn, sData, sSel;
   logic                cReady, cAccept, cFull, cFree, cAvail;
   logic                sReady, sAccept, sFull, sFree, sAvail;
   logic                grantS, grantAny, arbRun;

`ifdef NEO_PBUS_VFLIP_EN
   assign cLineEff = C_LINE ^ {CLINE_W{C_VFLIP}};
`else
   logic unused_vflip;
   assign unused_vflip = C_VFLIP;
   assign cLineEff     = C_LINE;
`endif

   assign cIn = {C_TILE, cLineEff};
   assign sIn = {S_TILE, S_HALF, S_LINE};

   assign cFree = (state_q == ST_STROBE) && (slot_q == SLOT_C);
   assign sFree = (state_q == ST_STROBE) && (slot_q == SLOT_S);

   neo_pbus_reqbuf #(.W(CA_W)) u_cbuf (
      .clk      (CLK),
      .rst_n    (nRESET),
      .valid_i  (C_VALID),
      .data_i   (cIn),
      .free_i   (cFree),
      .ready_o  (cReady),
      .accept_o (cAccept),
      .full_o   (cFull),
      .data_o   (cData)
   );

   neo_pbus_reqbuf #(.W(SA_W)) u_sbuf (
      .clk      (CLK),
      .rst_n    (nRESET),
      .valid_i  (S_VALID),
      .data_i   (sIn),
      .free_i   (sFree),
      .ready_o  (sReady),
      .accept_o (sAccept),
      .full_o   (sFull),
      .data_o   (sData)
   );

   // A buffer being freed this cycle only counts as pending if it is refilled at the same edge.
   assign cAvail = cFree ? cAccept : cFull;
   assign sAvail = sFree ? sAccept : sFull;
   assign cSel   = cFree ? cIn : cData;
   assign sSel   = sFree ? sIn : sData;

   assign grantS   = sAvail && (!cAvail || (fair_q == 4'(FAIR_MAX)));
   assign grantAny = cAvail || sAvail;

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= ST_IDLE;
         slot_q  <= SLOT_C;
         tmr_q   <= '0;
         fair_q  <= '0;
         pbus_q  <= '0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         tmr_q   <= tmr_d;
         fair_q  <= fair_d;
         pbus_q  <= pbus_d;
         oe_q    <= oe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      tmr_d   = tmr_q;
      fair_d  = sFull ? fair_q : 4'd0;
      pbus_d  = pbus_q;
      oe_d    = oe_q;
      arbRun  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            arbRun = 1'b1;
         end
         ST_SETUP: begin
            if (tmr_q == 3'd0) begin
               state_d = ST_STROBE;
            end else begin
               tmr_d = tmr_q - 3'd1;
            end
         end
         ST_STROBE: begin
            if (HOLD_CYC > 0) begin
               state_d = ST_HOLD;
               tmr_d   = 3'(HOLD_CYC - 1);
            end else begin
               arbRun = 1'b1;
            end
         end
         ST_HOLD: begin
            if (tmr_q == 3'd0) begin
               arbRun = 1'b1;
            end else begin
               tmr_d = tmr_q - 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // End of a slot (or idle): launch the next grant or release the bus.
      if (arbRun) begin
         if (grantAny) begin
            state_d = ST_SETUP;
            tmr_d   = 3'(SETUP_CYC - 1);
            oe_d    = 1'b1;
            if (grantS) begin
               slot_d = SLOT_S;
               pbus_d = packS(sSel);
               fair_d = 4'd0;
            end else begin
               slot_d = SLOT_C;
               pbus_d = packC(cSel);
               fair_d = sAvail ? (fair_q + 4'd1) : 4'd0;
            end
         end else begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
         end
      end
   end

   assign C_READY  = cReady;
   assign S_READY  = sReady;
   assign PBUS     = pbus_q;
   assign PBUS_OE  = oe_q;
   assign PCK1B_EN = (state_q == ST_STROBE) && (slot_q == SLOT_C);
   assign PCK2B_EN = (state_q == ST_STROBE) && (slot_q == SLOT_S);
   assign BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_neo_pbus_tx.sv
// Self-checking bench for neo_pbus_tx: scoreboard of accepted requests checked
// against each latch strobe, plus reset, fairness and HOLD_CYC=0 streaming.
`timescale 1ns/1ps
module tb_neo_pbus_tx;

   logic        CLK = 1'b0;
   logic        nRESET;
   logic        cValid, cVflip, sValid, sHalf;
   logic [15:0] cTile;
   logic [3:0]  cLine;
   logic [11:0] sTile;
   logic [2:0]  sLine;
   logic        cReady, sReady, oe, pck1, pck2, busy;
   logic [19:0] pbus;

   logic        hValid;
   logic [15:0] hTile;
   logic        hReady, hSReady, hOe, hPck1, hPck2, hBusy;
   logic [19:0] hPbus;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [19:0] addr;
      int          accCyc;
      int          expLat;
   } exp_t;

   exp_t cQ[$];
   exp_t sQ[$];
   logic orderQ[$];
   exp_t popE;

   int   cyc = 0;
   int   expLatency = 0;
   int   strobeCount = 0;
   logic prevStrobe = 1'b0;
   logic cAccNote = 1'b0, sAccNote = 1'b0, hAccNote = 1'b0;
   int   hStrobes = 0, hLast = 0;
   logic [3:0] cLineEff;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   neo_pbus_tx dut (
      .CLK(CLK), .nRESET(nRESET),
      .C_VALID(cValid), .C_READY(cReady), .C_TILE(cTile), .C_LINE(cLine), .C_VFLIP(cVflip),
      .S_VALID(sValid), .S_READY(sReady), .S_TILE(sTile), .S_HALF(sHalf), .S_LINE(sLine),
      .PBUS(pbus), .PBUS_OE(oe), .PCK1B_EN(pck1), .PCK2B_EN(pck2), .BUSY(busy)
   );

   neo_pbus_tx #(.SETUP_CYC(1), .HOLD_CYC(0), .FAIR_MAX(2)) dut0 (
      .CLK(CLK), .nRESET(nRESET),
      .C_VALID(hValid), .C_READY(hReady), .C_TILE(hTile), .C_LINE(4'h1), .C_VFLIP(1'b0),
      .S_VALID(1'b0), .S_READY(hSReady), .S_TILE(12'h000), .S_HALF(1'b0), .S_LINE(3'h0),
      .PBUS(hPbus), .PBUS_OE(hOe), .PCK1B_EN(hPck1), .PCK2B_EN(hPck2), .BUSY(hBusy)
   );

`ifdef NEO_PBUS_VFLIP_EN
   assign cLineEff = cLine ^ {4{cVflip}};
`else
   assign cLineEff = cLine;
`endif

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: pop on each strobe, push on each handshake seen before the coming edge.
   always @(negedge CLK) begin
      if (!nRESET) begin
         prevStrobe = 1'b0;
         cAccNote   = 1'b0;
         sAccNote   = 1'b0;
         hAccNote   = 1'b0;
      end else begin
         if (pck1 || pck2) begin
            checkOutput("oneHot", {31'b0, pck1 & pck2}, 32'd0);
            checkOutput("pulseLen", {31'b0, prevStrobe}, 32'd0);
            if (pck1) begin
               if (cQ.size() == 0) checkOutput("spuriousC", 32'd1, 32'd0);
               else begin
                  popE = cQ.pop_front();
                  checkOutput("cPbus", {12'b0, pbus}, {12'b0, popE.addr[3:0], popE.addr[19:4]});
                  checkOutput("cLatch", {12'b0, pbus[15:0], pbus[19:16]}, {12'b0, popE.addr});
                  if (popE.expLat > 0) checkOutput("cLatency", cyc - popE.accCyc, popE.expLat);
               end
            end
            if (pck2) begin
               if (sQ.size() == 0) checkOutput("spuriousS", 32'd1, 32'd0);
               else begin
                  popE = sQ.pop_front();
                  checkOutput("sPbus", {12'b0, pbus}, {12'b0, 4'h0, popE.addr[3:0], popE.addr[15:4]});
                  checkOutput("sLatch", {16'b0, pbus[11:0], pbus[15:12]}, {16'b0, popE.addr[15:0]});
                  if (popE.expLat > 0) checkOutput("sLatency", cyc - popE.accCyc, popE.expLat);
               end
            end
            if (orderQ.size() > 0) checkOutput("grantOrder", {31'b0, pck2}, {31'b0, orderQ.pop_front()});
            strobeCount++;
         end
         prevStrobe = pck1 | pck2;
         cAccNote = cValid && cReady;
         sAccNote = sValid && sReady;
         if (cAccNote) cQ.push_back('{addr: {cTile, cLineEff}, accCyc: cyc + 1, expLat: expLatency});
         if (sAccNote) sQ.push_back('{addr: {4'h0, sTile, sHalf, sLine}, accCyc: cyc + 1, expLat: expLatency});

         if (hPck1) begin
            if (hStrobes > 0) checkOutput("h0Interval", cyc - hLast, 32'd2);
            hStrobes++;
            hLast = cyc;
         end
         if (hStrobes > 0 && hStrobes < 4) checkOutput("h0Oe", {31'b0, hOe}, 32'd1);
         checkOutput("h0NoS", {31'b0, hPck2}, 32'd0);
         hAccNote = hValid && hReady;
      end
   end

   task automatic applyStimulus(input logic isS, input logic [15:0] tile, input logic [3:0] line,
                                input logic flag);
      int n;
      @(posedge CLK); #1;
      if (isS) begin
         sTile = tile[11:0]; sLine = line[2:0]; sHalf = flag; sValid = 1'b1;
      end else begin
         cTile = tile; cLine = line; cVflip = flag; cValid = 1'b1;
      end
      for (n = 0; n < 50; n++) begin
         @(negedge CLK);
         if (isS ? sReady : cReady) break;
      end
      if (n == 50) checkOutput("readyTimeout", 32'd1, 32'd0);
      @(posedge CLK); #1;
      cValid = 1'b0;
      sValid = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      for (n = 0; n < 100; n++) begin
         @(negedge CLK);
         if (!busy && cQ.size() == 0 && sQ.size() == 0) break;
      end
      if (n == 100) checkOutput("idleTimeout", 32'd1, 32'd0);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL globalTimeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      nRESET = 1'b0;
      cValid = 1'b0; cVflip = 1'b0; cTile = '0; cLine = '0;
      sValid = 1'b0; sHalf = 1'b0; sTile = '0; sLine = '0;
      hValid = 1'b0; hTile = 16'h0010;

      repeat (3) @(posedge CLK);
      #1;
      checkOutput("rstPbus", {12'b0, pbus}, 32'd0);
      checkOutput("rstOe", {31'b0, oe}, 32'd0);
      checkOutput("rstCReady", {31'b0, cReady}, 32'd0);
      checkOutput("rstSReady", {31'b0, sReady}, 32'd0);
      checkOutput("rstBusy", {31'b0, busy}, 32'd0);
      checkOutput("rstStrobes", {30'b0, pck1, pck2}, 32'd0);
      @(negedge CLK);
      nRESET = 1'b1;
      #1 checkOutput("readyBeforeEdge", {31'b0, cReady}, 32'd0);
      @(posedge CLK); #1;
      checkOutput("readyAfterEdgeC", {31'b0, cReady}, 32'd1);
      checkOutput("readyAfterEdgeS", {31'b0, sReady}, 32'd1);

      // Idle-block C fetch
      expLatency = 2;
      applyStimulus(1'b0, 16'hABCD, 4'h3, 1'b0);
      checkOutput("cBufBusy", {31'b0, cReady}, 32'd0);
      @(posedge CLK); #1;
      checkOutput("setupOe", {31'b0, oe}, 32'd1);
      checkOutput("setupWord", {12'b0, pbus}, 32'h3ABCD);
      @(posedge CLK); #1;
      checkOutput("strobeC", {31'b0, pck1}, 32'd1);
      @(posedge CLK); #1;
      checkOutput("cReadyAfter", {31'b0, cReady}, 32'd1);
      waitIdle();
      checkOutput("idleOe", {31'b0, oe}, 32'd0);
      checkOutput("idleKeepsWord", {12'b0, pbus}, 32'h3ABCD);

      // Idle-block S fetch
      applyStimulus(1'b1, 16'h0123, 4'h5, 1'b1);
      @(posedge CLK); #1;
      checkOutput("setupWordS", {16'b0, pbus[15:0]}, 32'hD123);
      waitIdle();

      // Vertical flip
      expLatency = 0;
      applyStimulus(1'b0, 16'h0000, 4'h2, 1'b1);
      @(posedge CLK); #1;
`ifdef NEO_PBUS_VFLIP_EN
      checkOutput("vflipNibble", {28'b0, pbus[19:16]}, 32'hD);
`else
      checkOutput("vflipNibble", {28'b0, pbus[19:16]}, 32'h2);
`endif
      waitIdle();

      // Fairness: continuous C with S pending
      orderQ.push_back(1'b0); orderQ.push_back(1'b0); orderQ.push_back(1'b1);
      orderQ.push_back(1'b0); orderQ.push_back(1'b0); orderQ.push_back(1'b1);
      strobeCount = 0;
      @(posedge CLK); #1;
      cTile = 16'h0100; cLine = 4'h7; cVflip = 1'b0; cValid = 1'b1;
      sTile = 12'h200; sLine = 3'h1; sHalf = 1'b0; sValid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge CLK); #1;
         if (cAccNote) cTile = cTile + 16'd1;
         if (sAccNote) sTile = sTile + 12'd1;
         if (strobeCount >= 6) break;
      end
      cValid = 1'b0;
      sValid = 1'b0;
      checkOutput("fairStrobes", (strobeCount >= 6) ? 32'd1 : 32'd0, 32'd1);
      waitIdle();

      // Reset in the SETUP cycle aborts the slot
      applyStimulus(1'b0, 16'h5555, 4'h1, 1'b0);
      @(posedge CLK); #1;
      checkOutput("abortInSetup", {30'b0, busy, pck1}, 32'd2);
      nRESET = 1'b0;
      #1;
      cQ.delete();
      sQ.delete();
      checkOutput("abortPbus", {12'b0, pbus}, 32'd0);
      checkOutput("abortOe", {31'b0, oe}, 32'd0);
      checkOutput("abortReady", {30'b0, cReady, sReady}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         checkOutput("abortNoStrobe", {30'b0, pck1, pck2}, 32'd0);
      end
      nRESET = 1'b1;
      @(posedge CLK); #1;
      checkOutput("abortReadyBack", {30'b0, cReady, sReady}, 32'd3);
      repeat (5) @(posedge CLK);
      #1 checkOutput("abortStaysIdle", {31'b0, busy}, 32'd0);

      // HOLD_CYC=0 streaming on the second instance
      hStrobes = 0;
      @(posedge CLK); #1;
      hValid = 1'b1;
      begin
         int acc = 0;
         for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            if (hAccNote) begin
               acc++;
               hTile = hTile + 16'd1;
               if (acc == 4) hValid = 1'b0;
            end
            if (hStrobes >= 4) break;
         end
      end
      hValid = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      checkOutput("h0Strobes", hStrobes, 32'd4);
      checkOutput("h0Idle", {31'b0, hOe}, 32'd0);

      checkOutput("cDrain", cQ.size(), 32'd0);
      checkOutput("sDrain", sQ.size(), 32'd0);
      checkOutput("orderDrain", orderQ.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
